// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: write-pointer synchroniser, read pointer, FWFT output with 2-entry stage.
// Optional almost_empty output is enabled by defining FIFO_ALMOST_EMPTY_EN.
module fifo_rd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr_gray_async,
  output logic [ADDR_W:0]   rd_ptr_bin,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   rd_level
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic              almost_empty
`endif
);

  localparam int PW = ADDR_W + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("fifo_rd_ctrl: SYNC_STAGES must be in 2..4");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > (1 << ADDR_W)) begin : g_bad_ae
    $error("fifo_rd_ctrl: AE_LEVEL out of range");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]     sync_d [SYNC_STAGES];
  logic [PW-1:0]     sync_q [SYNC_STAGES];
  logic [PW-1:0]     wr_ptr_bin_sync;

  logic [PW-1:0]     rd_ptr_bin_d,  rd_ptr_bin_q;
  logic [PW-1:0]     rd_ptr_gray_d, rd_ptr_gray_q;
  logic              pending_d,     pending_q;
  logic [DATA_W-1:0] dout_d,        dout_q;
  logic              dout_valid_d,  dout_valid_q;
  logic [DATA_W-1:0] skid_d,        skid_q;
  logic              skid_valid_d,  skid_valid_q;

  logic [PW-1:0]     rd_ptr_inc;
  logic [1:0]        occ;
  logic              pop;
  logic              empty;
  logic              ren;

  always_comb begin
    sync_d[0] = wr_ptr_gray_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wr_ptr_bin_sync = gray2bin(sync_q[SYNC_STAGES-1]);
  assign empty           = (rd_ptr_bin_q == wr_ptr_bin_sync);
  assign rd_ptr_inc      = rd_ptr_bin_q + PW'(1);

  assign pop = dout_valid_q && dout_ready;
  assign occ = 2'(dout_valid_q) + 2'(skid_valid_q) + 2'(pending_q);
  // Gated by rst_n so no RAM read is issued while reset is being applied.
  assign ren = rst_n && !empty && ((occ - 2'(pop)) < 2'd2);

  always_comb begin
    rd_ptr_bin_d  = rd_ptr_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    pending_d     = 1'b0;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;

    if (ren) begin
      rd_ptr_bin_d  = rd_ptr_inc;
      rd_ptr_gray_d = bin2gray(rd_ptr_inc);
      pending_d     = 1'b1;
    end

    if (pop) begin
      if (skid_valid_q) begin
        dout_d = skid_q;
        if (pending_q) begin
          skid_d = mem_rdata;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (pending_q) begin
        dout_d = mem_rdata;
      end else begin
        dout_valid_d = 1'b0;
      end
    end else if (pending_q) begin
      // Issue rule guarantees the skid slot is free whenever dout is occupied here.
      if (!dout_valid_q) begin
        dout_d       = mem_rdata;
        dout_valid_d = 1'b1;
      end else begin
        skid_d       = mem_rdata;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      pending_q     <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      pending_q     <= pending_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  assign rd_ptr_bin  = rd_ptr_bin_q;
  assign rd_ptr_gray = rd_ptr_gray_q;
  assign mem_ren     = ren;
  assign mem_raddr   = rd_ptr_bin_q[ADDR_W-1:0];
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign fifo_empty  = empty;
  assign rd_level    = wr_ptr_bin_sync - rd_ptr_bin_q;

`ifdef FIFO_ALMOST_EMPTY_EN
  assign almost_empty = (rd_level <= PW'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: per-cycle vector table for the single-word path,
// plus hand-written stream, backpressure, wrap and mid-stream reset sequences.
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] rd_bin, rd_gray;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] dout;
  logic          dv;
  logic          ready;
  logic          empty;
  logic [PW-1:0] level;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic          almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [16];
  logic [DW-1:0] exp_q [$];
  int            wp   = 0;
  int            wseq = 0;
  int            rcv  = 0;
  logic          mon_en = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .AE_LEVEL(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_ptr_gray_async (wr_gray),
    .rd_ptr_bin        (rd_bin),
    .rd_ptr_gray       (rd_gray),
    .mem_ren           (ren),
    .mem_raddr         (raddr),
    .mem_rdata         (rdata),
    .dout              (dout),
    .dout_valid        (dv),
    .dout_ready        (ready),
    .fifo_empty        (empty),
    .rd_level          (level)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .almost_empty      (almost_empty)
`endif
  );

  // Synchronous-read RAM model.
  always @(posedge clk) if (ren) rdata <= ram[raddr];

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [DW-1:0] wval(input int n);
    return DW'(n * 37 + 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      ram[wp & 15] = wval(wseq);
      exp_q.push_back(wval(wseq));
      wseq++;
      wp++;
    end
  endtask

  task automatic publish();
    wr_gray = gray(wp);
  endtask

  task automatic run_len(input int budget, output int n);
    int t;
    n = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (dv !== 1'b1 && t < budget);
    chk("run_start", {31'd0, dv}, 32'd1);
    while (dv === 1'b1 && ready === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Scoreboard, hold-stability, level bound and wrap observation.
  logic          hold_p   = 1'b0;
  logic [DW-1:0] hold_d   = '0;
  logic [PW-1:0] prev_bin = '0;
  logic          saw_wrap = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en) begin
      if (dv && ready) begin
        rcv++;
        if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else begin
          chk("pop_data", {24'd0, dout}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      if (hold_p && dv) chk("hold_stable", {24'd0, dout}, {24'd0, hold_d});
      hold_p = dv && !ready;
      hold_d = dout;
      chk("level_le_16", {31'd0, (level > 5'd16)}, 32'd0);
      if (prev_bin == 5'd31 && rd_bin == 5'd0) saw_wrap = 1'b1;
      prev_bin = rd_bin;
    end else begin
      hold_p = 1'b0;
    end
  end

  typedef struct {
    logic [PW-1:0] wr_gray;
    logic          ready;
    logic          exp_empty;
    logic          exp_ren;
    logic [PW-1:0] exp_bin;
    logic [PW-1:0] exp_gray;
    logic          exp_dv;
    logic [PW-1:0] exp_level;
  } vec_t;

  vec_t tv [7];

  initial begin
    int n;
    int pulses;
    int base;
    int t;

    tv[0] = '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0};
    tv[1] = '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0};
    tv[2] = '{5'd1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd1};
    tv[3] = '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0, 5'd0};
    tv[4] = '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 1'b1, 5'd0};
    tv[5] = '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0, 5'd0};
    tv[6] = '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0, 5'd0};

    for (int i = 0; i < 16; i++) ram[i] = '0;
    ready   = 1'b1;
    rst_n   = 1'b0;
    wr_gray = 5'b00011;

    // Reset held for 3 cycles with a non-zero write pointer at the input.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_state", {6'd0, dv, dout, empty, level, ren, rd_bin, rd_gray},
          {6'd0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0});
    end
    wr_gray = 5'd0;
    rst_n   = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(posedge clk);

    // Single word, cycle by cycle.
    load_words(1);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      wr_gray = tv[k].wr_gray;
      ready   = tv[k].ready;
      @(negedge clk);
      chk($sformatf("single_vec%0d", k),
          {14'd0, empty, ren, rd_bin, rd_gray, dv, level},
          {14'd0, tv[k].exp_empty, tv[k].exp_ren, tv[k].exp_bin, tv[k].exp_gray,
           tv[k].exp_dv, tv[k].exp_level});
      if (tv[k].exp_dv) chk("single_dout", {24'd0, dout}, {24'd0, wval(0)});
    end

    // Fresh start, then a full 16-word stream.
    @(posedge clk); #1;
    rst_n = 1'b0; wr_gray = 5'd0;
    @(posedge clk); #1;
    exp_q.delete(); wp = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_words(16);
    publish();
    run_len(20, n);
    chk("stream_len", n, 16);
    chk("stream_end", {21'd0, rd_bin, rd_gray, empty}, {21'd0, 5'b10000, 5'b11000, 1'b1});
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: only two reads may be in the output stage.
    @(posedge clk); #1;
    ready = 1'b0;
    load_words(8);
    publish();
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (ren) pulses++;
    end
    chk("bp_ren_pulses", pulses, 2);
    chk("bp_valid", {31'd0, dv}, 32'd1);
    chk("bp_dout", {24'd0, dout}, {24'd0, exp_q[0]});
    @(posedge clk); #1;
    ready = 1'b1;
    run_len(5, n);
    chk("bp_drain_len", n, 8);

    // Wrap: 40 more words in bursts of 8 takes the pointer across 31->0 twice.
    saw_wrap = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      load_words(8);
      publish();
      run_len(20, n);
      chk("wrap_burst", n, 8);
    end
    chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);
    chk("wrap_ptr", {27'd0, rd_bin}, {27'd0, PW'(wp)});
    chk("wrap_drained", exp_q.size(), 0);

    // Reset in the middle of a 10-word transfer.
    @(posedge clk); #1;
    load_words(10);
    publish();
    base = rcv;
    t = 0;
    while (rcv < base + 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mid_progress", {31'd0, (rcv - base >= 5)}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    wr_gray = 5'd0;
    @(negedge clk);
    chk("mid_rst_ren", {31'd0, ren}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_dv", {31'd0, dv}, 32'd0);
    chk("mid_rst_ptr", {22'd0, rd_bin, rd_gray}, 32'd0);
    exp_q.delete();
    wp = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Recovery after reset.
    @(posedge clk); #1;
    load_words(3);
    publish();
    run_len(20, n);
    chk("recover_len", n, 3);
    chk("recover_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
